// File: rtl/xgmii_link_monitor_if.sv
// Bus bundle between the XGMII receive stream and the link monitor.
// The XGMII_LINK_MONITOR_CAPTURE_EN macro adds the last_word capture output.
interface xgmii_link_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic                      clr;
    logic                      snap;
    logic [NUM_CH-1:0]         link_status;
    logic [NUM_CH*64-1:0]      xgmii_rxd;
    logic [NUM_CH*8-1:0]       xgmii_rxc;
    logic [NUM_CH*CNT_W-1:0]   link_up_cnt;
    logic [NUM_CH*CNT_W-1:0]   good_frm_cnt;
    logic [NUM_CH*CNT_W-1:0]   bad_frm_cnt;
    logic [NUM_CH*CNT_W-1:0]   err_cnt;
    logic                      snap_valid;
    logic [NUM_CH-1:0]         in_frame;
`ifdef XGMII_LINK_MONITOR_CAPTURE_EN
    logic [NUM_CH*72-1:0]      last_word;
`endif

    // Stimulus / PCS side
    modport master (
        output clr, snap, link_status, xgmii_rxd, xgmii_rxc,
        input  link_up_cnt, good_frm_cnt, bad_frm_cnt, err_cnt, snap_valid, in_frame
`ifdef XGMII_LINK_MONITOR_CAPTURE_EN
        , input last_word
`endif
    );

    // Monitor side
    modport slave (
        input  clr, snap, link_status, xgmii_rxd, xgmii_rxc,
        output link_up_cnt, good_frm_cnt, bad_frm_cnt, err_cnt, snap_valid, in_frame
`ifdef XGMII_LINK_MONITOR_CAPTURE_EN
        , output last_word
`endif
    );
endinterface

// File: rtl/xgmii_link_monitor.sv
// Multi-channel receive-side XGMII monitor: link-up, good/bad frame and
// error-word counters with saturating arithmetic, clear and snapshot bank.
// Optional macro XGMII_LINK_MONITOR_CAPTURE_EN adds per-channel last_word capture.
module xgmii_link_monitor #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    xgmii_link_monitor_if.slave  bus
);
    typedef enum logic {S_IDLE, S_IN_FRAME} state_t;

    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERROR = 8'hFE;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    state_t            r_state [NUM_CH];
    logic [NUM_CH-1:0] r_frame_bad;
    logic [NUM_CH-1:0] r_link_prev;
    logic [CNT_W-1:0]  r_link_up [NUM_CH];
    logic [CNT_W-1:0]  r_good    [NUM_CH];
    logic [CNT_W-1:0]  r_bad     [NUM_CH];
    logic [CNT_W-1:0]  r_err     [NUM_CH];
    logic [CNT_W-1:0]  r_snap_link_up [NUM_CH];
    logic [CNT_W-1:0]  r_snap_good    [NUM_CH];
    logic [CNT_W-1:0]  r_snap_bad     [NUM_CH];
    logic [CNT_W-1:0]  r_snap_err     [NUM_CH];
    logic              r_snap_valid;

    logic [NUM_CH-1:0] w_sof, w_sof4, w_eof, w_eof_lo, w_err;
    logic [NUM_CH-1:0] w_good_inc, w_bad_inc;

    // Per-lane control-character decode of the current word
    always_comb begin
        w_sof    = '0;
        w_sof4   = '0;
        w_eof    = '0;
        w_eof_lo = '0;
        w_err    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.xgmii_rxc[c*8+i]) begin
                    if (bus.xgmii_rxd[c*64+i*8 +: 8] == C_TERM) begin
                        w_eof[c] = 1'b1;
                        if (i < 4) w_eof_lo[c] = 1'b1;
                    end
                    if (bus.xgmii_rxd[c*64+i*8 +: 8] == C_ERROR)
                        w_err[c] = 1'b1;
                    if ((bus.xgmii_rxd[c*64+i*8 +: 8] == C_START) && (i == 0 || i == 4)) begin
                        w_sof[c] = 1'b1;
                        if (i == 4) w_sof4[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Frame outcome of this word: close (good/bad), truncation, or link loss
    always_comb begin
        w_good_inc = '0;
        w_bad_inc  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!bus.link_status[c]) begin
                w_bad_inc[c] = (r_state[c] == S_IN_FRAME);
            end else if (r_state[c] == S_IN_FRAME) begin
                if (w_eof[c]) begin
                    if (r_frame_bad[c] || w_err[c]) w_bad_inc[c]  = 1'b1;
                    else                            w_good_inc[c] = 1'b1;
                end else if (w_sof[c]) begin
                    w_bad_inc[c] = 1'b1;
                end
            end
        end
    end

    // Frame FSM per channel; a closing EOF in lanes 0..3 with SOF in lane 4 reopens at once
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) r_state[c] <= S_IDLE;
            r_frame_bad <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!bus.link_status[c]) begin
                    r_state[c]     <= S_IDLE;
                    r_frame_bad[c] <= 1'b0;
                end else if (r_state[c] == S_IDLE) begin
                    if (w_sof[c]) begin
                        r_state[c]     <= S_IN_FRAME;
                        r_frame_bad[c] <= w_err[c];
                    end
                end else begin
                    if (w_eof[c] && w_eof_lo[c] && w_sof4[c]) begin
                        r_frame_bad[c] <= 1'b0;
                    end else if (w_eof[c]) begin
                        r_state[c]     <= S_IDLE;
                        r_frame_bad[c] <= 1'b0;
                    end else if (w_sof[c]) begin
                        r_frame_bad[c] <= w_err[c];
                    end else if (w_err[c]) begin
                        r_frame_bad[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Previous link status for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) r_link_prev <= '0;
        else     r_link_prev <= bus.link_status;
    end

    // Live saturating counters; clr wins over any same-cycle increment
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst || bus.clr) begin
                r_link_up[c] <= '0;
                r_good[c]    <= '0;
                r_bad[c]     <= '0;
                r_err[c]     <= '0;
            end else begin
                r_link_up[c] <= sat_inc(r_link_up[c], bus.link_status[c] & ~r_link_prev[c]);
                r_good[c]    <= sat_inc(r_good[c], w_good_inc[c]);
                r_bad[c]     <= sat_inc(r_bad[c], w_bad_inc[c]);
                r_err[c]     <= sat_inc(r_err[c], w_err[c]);
            end
        end
    end

    // Snapshot bank captures pre-edge live values on snap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_snap_link_up[c] <= '0;
                r_snap_good[c]    <= '0;
                r_snap_bad[c]     <= '0;
                r_snap_err[c]     <= '0;
            end
        end else begin
            r_snap_valid <= bus.snap;
            if (bus.snap) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_snap_link_up[c] <= r_link_up[c];
                    r_snap_good[c]    <= r_good[c];
                    r_snap_bad[c]     <= r_bad[c];
                    r_snap_err[c]     <= r_err[c];
                end
            end
        end
    end

    assign bus.snap_valid = r_snap_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.link_up_cnt[g*CNT_W +: CNT_W]  = r_snap_link_up[g];
        assign bus.good_frm_cnt[g*CNT_W +: CNT_W] = r_snap_good[g];
        assign bus.bad_frm_cnt[g*CNT_W +: CNT_W]  = r_snap_bad[g];
        assign bus.err_cnt[g*CNT_W +: CNT_W]      = r_snap_err[g];
        assign bus.in_frame[g]                    = (r_state[g] == S_IN_FRAME);
    end

`ifdef XGMII_LINK_MONITOR_CAPTURE_EN
    logic [71:0] r_last [NUM_CH];

    // Hold the most recent word that is not a full idle word
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst)
                r_last[c] <= '0;
            else if (!((bus.xgmii_rxc[c*8 +: 8] == 8'hFF) &&
                       (bus.xgmii_rxd[c*64 +: 64] == 64'h0707070707070707)))
                r_last[c] <= {bus.xgmii_rxc[c*8 +: 8], bus.xgmii_rxd[c*64 +: 64]};
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cap
        assign bus.last_word[g*72 +: 72] = r_last[g];
    end
`endif
endmodule

// File: tb/tb_xgmii_link_monitor.sv
// Directed bench for xgmii_link_monitor (NUM_CH=2, CNT_W=8 so saturation is reachable).
module tb_xgmii_link_monitor;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] SOF_D  = 64'hD5555555555555FB;   // SOF lane 0
    localparam logic [7:0]  SOF_C  = 8'h01;
    localparam logic [63:0] DAT_D  = 64'hA1B2C3D4E5F60718;
    localparam logic [7:0]  DAT_C  = 8'h00;
    localparam logic [63:0] EOF2_D = 64'h0707070707FD2211;   // EOF lane 2
    localparam logic [7:0]  EOF2_C = 8'hFC;
    localparam logic [63:0] EOF0_D = 64'h07070707070707FD;   // EOF lane 0
    localparam logic [7:0]  EOF0_C = 8'hFF;
    localparam logic [63:0] ERR3_D = 64'h88776655FE332211;   // /E/ in lane 3
    localparam logic [7:0]  ERR3_C = 8'h08;
    localparam logic [63:0] ES_D   = 64'h555555FB0707FDAA;   // EOF lane 1 + SOF lane 4
    localparam logic [7:0]  ES_C   = 8'h1E;
    localparam logic [63:0] ERRA_D = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [7:0]  ERRA_C = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    xgmii_link_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    xgmii_link_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic [63:0] d, input logic [7:0] k);
        bus.xgmii_rxd[c*64 +: 64] = d;
        bus.xgmii_rxc[c*8 +: 8]   = k;
    endtask

    task automatic send(input int c, input logic [63:0] d, input logic [7:0] k);
        put(c, d, k);
        tick();
        put(c, IDLE_D, IDLE_C);
    endtask

    task automatic do_snap();
        bus.snap = 1'b1;
        tick();
        bus.snap = 1'b0;
        check("snap_valid", {71'd0, bus.snap_valid}, 72'd1);
    endtask

    function automatic logic [71:0] cnt(input logic [NUM_CH*CNT_W-1:0] v, input int c);
        return {64'd0, v[c*CNT_W +: CNT_W]};
    endfunction

    initial begin
        rst = 1'b1;
        bus.clr = 1'b0;
        bus.snap = 1'b0;
        bus.link_status = 2'b01;
        put(0, IDLE_D, IDLE_C);
        put(1, IDLE_D, IDLE_C);
        tick();
        tick();
        check("rst_in_frame", {70'd0, bus.in_frame}, 72'd0);
        check("rst_snap_valid", {71'd0, bus.snap_valid}, 72'd0);
        check("rst_link_up0", cnt(bus.link_up_cnt, 0), 72'd0);
        check("rst_err0", cnt(bus.err_cnt, 0), 72'd0);

        // Link already high at reset release counts once
        rst = 1'b0;
        tick();
        tick();
        do_snap();
        check("lu0_release", cnt(bus.link_up_cnt, 0), 72'd1);
        check("lu1_low", cnt(bus.link_up_cnt, 1), 72'd0);
        check("good0_init", cnt(bus.good_frm_cnt, 0), 72'd0);
        check("bad0_init", cnt(bus.bad_frm_cnt, 0), 72'd0);
        check("err0_init", cnt(bus.err_cnt, 0), 72'd0);
        tick();
        check("snap_valid_pulse", {71'd0, bus.snap_valid}, 72'd0);

        // ch1: five clean frames
        bus.link_status = 2'b11;
        for (int f = 0; f < 5; f++) begin
            send(1, SOF_D, SOF_C);
            check("ch1_in_frame_sof", {71'd0, bus.in_frame[1]}, 72'd1);
            for (int w = 0; w < 3; w++) send(1, DAT_D, DAT_C);
            send(1, EOF2_D, EOF2_C);
            check("ch1_in_frame_eof", {71'd0, bus.in_frame[1]}, 72'd0);
        end
        do_snap();
        check("ch1_good5", cnt(bus.good_frm_cnt, 1), 72'd5);
        check("ch1_bad0", cnt(bus.bad_frm_cnt, 1), 72'd0);
        check("ch1_link_up", cnt(bus.link_up_cnt, 1), 72'd1);

        // ch0: errored frame, then truncated frame followed by a good one
        send(0, SOF_D, SOF_C);
        send(0, ERR3_D, ERR3_C);
        send(0, EOF0_D, EOF0_C);
        do_snap();
        check("ch0_bad1", cnt(bus.bad_frm_cnt, 0), 72'd1);
        check("ch0_err1", cnt(bus.err_cnt, 0), 72'd1);
        check("ch0_good0", cnt(bus.good_frm_cnt, 0), 72'd0);
        send(0, SOF_D, SOF_C);
        send(0, SOF_D, SOF_C);
        send(0, EOF0_D, EOF0_C);
        do_snap();
        check("ch0_bad2", cnt(bus.bad_frm_cnt, 0), 72'd2);
        check("ch0_good1", cnt(bus.good_frm_cnt, 0), 72'd1);

        // EOF+SOF in one word, then link drop mid-frame
        send(0, SOF_D, SOF_C);
        send(0, DAT_D, DAT_C);
        send(0, ES_D, ES_C);
        check("ch0_es_in_frame", {71'd0, bus.in_frame[0]}, 72'd1);
        send(0, DAT_D, DAT_C);
        send(0, EOF0_D, EOF0_C);
        check("ch0_es_closed", {71'd0, bus.in_frame[0]}, 72'd0);
        send(0, SOF_D, SOF_C);
        send(0, DAT_D, DAT_C);
        bus.link_status = 2'b10;
        tick();
        check("ch0_drop_in_frame", {71'd0, bus.in_frame[0]}, 72'd0);
        send(0, SOF_D, SOF_C);
        check("ch0_sof_link_low", {71'd0, bus.in_frame[0]}, 72'd0);
        bus.link_status = 2'b11;
        tick();
        send(0, EOF0_D, EOF0_C);
        do_snap();
        check("ch0_good3", cnt(bus.good_frm_cnt, 0), 72'd3);
        check("ch0_bad3", cnt(bus.bad_frm_cnt, 0), 72'd3);
        check("ch0_lu2", cnt(bus.link_up_cnt, 0), 72'd2);
        check("ch0_err_still1", cnt(bus.err_cnt, 0), 72'd1);

        // Saturation, clr+snap same cycle, clr beating an increment
        for (int w = 0; w < 300; w++) send(0, ERRA_D, ERRA_C);
        do_snap();
        check("ch0_err_sat", cnt(bus.err_cnt, 0), 72'd255);
        bus.clr = 1'b1;
        do_snap();
        bus.clr = 1'b0;
        check("clr_snap_pre", cnt(bus.err_cnt, 0), 72'd255);
        bus.clr = 1'b1;
        send(0, ERRA_D, ERRA_C);
        bus.clr = 1'b0;
        do_snap();
        check("clr_wins_err", cnt(bus.err_cnt, 0), 72'd0);
        check("clr_good0", cnt(bus.good_frm_cnt, 0), 72'd0);
        send(0, ERRA_D, ERRA_C);
        do_snap();
        check("err_after_clr", cnt(bus.err_cnt, 0), 72'd1);

`ifdef XGMII_LINK_MONITOR_CAPTURE_EN
        send(0, 64'h1122334455667788, 8'h00);
        tick();
        tick();
        check("cap_ch0", bus.last_word[71:0], 72'h00_1122334455667788);
        check("cap_ch1", bus.last_word[143:72], {EOF2_C, EOF2_D});
`endif

        // Reset mid-frame discards the frame
        send(1, SOF_D, SOF_C);
        send(1, DAT_D, DAT_C);
        rst = 1'b1;
        tick();
        check("rst_mid_in_frame", {71'd0, bus.in_frame[1]}, 72'd0);
        check("rst_mid_snap_good1", cnt(bus.good_frm_cnt, 1), 72'd0);
`ifdef XGMII_LINK_MONITOR_CAPTURE_EN
        check("cap_rst", bus.last_word[71:0], 72'd0);
`endif
        rst = 1'b0;
        tick();
        do_snap();
        check("post_rst_bad1", cnt(bus.bad_frm_cnt, 1), 72'd0);
        check("post_rst_good1", cnt(bus.good_frm_cnt, 1), 72'd0);
        check("post_rst_lu1", cnt(bus.link_up_cnt, 1), 72'd1);
        check("post_rst_lu0", cnt(bus.link_up_cnt, 0), 72'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/xgmii_link_monitor.md
Name: xgmii_link_monitor

Overview:
Multi-channel receive-side XGMII monitor for the 10GBASE-R SFP test designs. Per channel it tracks:
- link-up events,
- good and bad frames (via a start/terminate state machine),
- control-error words.

Counters are saturating, clearable, and can be frozen into a snapshot register bank for VIO/debug readout. It sits on the coreclk domain directly after each PCS/PMA instance's xgmii_rxd/xgmii_rxc outputs.

Parameters:
NUM_CH, 2, number of monitored channels (1..8)
CNT_W, 32, width of every counter (8..64)

Ports:
clk  in  1  coreclk; all logic on posedge
rst  in  1  synchronous, active-high reset
clr  in  1  one-cycle pulse; zero all live counters
snap  in  1  one-cycle pulse; copy live counters to snapshot bank
link_status  in  NUM_CH  per-channel PCS rx link status (core_status[0])
xgmii_rxd  in  NUM_CH*64  channel c at [c*64 +: 64]; lane i = byte [i*8 +: 8]
xgmii_rxc  in  NUM_CH*8  channel c at [c*8 +: 8]; bit i = control flag of lane i
link_up_cnt  out  NUM_CH*CNT_W  snapshot: rising edges of link_status
good_frm_cnt  out  NUM_CH*CNT_W  snapshot: frames closed without error
bad_frm_cnt  out  NUM_CH*CNT_W  snapshot: errored/truncated/aborted frames
err_cnt  out  NUM_CH*CNT_W  snapshot: words containing any /E/ control byte
snap_valid  out  1  one-cycle pulse; snapshot bank updated
in_frame  out  NUM_CH  live per-channel frame FSM state (1 = IN_FRAME)

Behaviour:
Decode, per channel, per word:
- SOF = lane 0 or lane 4 with rxc=1 and byte 0xFB.
- EOF = any lane with rxc=1 and byte 0xFD; eof_lane = lowest such lane.
- ERR = any lane with rxc=1 and byte 0xFE.

Frame FSM, per channel: states IDLE, IN_FRAME, plus a frame_bad flag.
- IDLE + SOF -> IN_FRAME; frame_bad = ERR.
- IN_FRAME + ERR -> frame_bad = 1.
- IN_FRAME + EOF -> IDLE; good_frm++ if !frame_bad, else bad_frm++.
- IN_FRAME + SOF with no EOF in the same word -> truncated frame: bad_frm++, stay IN_FRAME, frame_bad = ERR.
- Same word with EOF in lanes 0..3 and SOF in lane 4, while IN_FRAME -> close the current frame (counted as above), then open a new one; frame_bad = 0.
- EOF while IDLE -> ignored, no count.
- link_status low while IN_FRAME -> bad_frm++, go to IDLE. While link_status is low the FSM is held in IDLE and SOF is ignored.

Other counters:
- err_cnt increments by 1 per word with ERR, regardless of FSM state or link.
- link_up_cnt increments when link_status is 1 and its registered previous value is 0. The previous-value register resets to 0, so a link already high at reset release counts once.

Counter arithmetic:
- All counters saturate at {CNT_W{1'b1}}; no wrap.
- A single word adds at most 1 to each counter, except bad_frm in the EOF+SOF same-word case: still at most 1 good or 1 bad.

Timing:
- Live counters and in_frame update on the edge that samples the word; 1-cycle latency.

clr / snap:
- clr: live counters and FSMs unaffected except counters forced to 0. clr beats any same-cycle increment, so the result is 0.
- snap at cycle N: snapshot bank = live values as they stood before edge N (pre-clr if clr is in the same cycle). snap_valid = 1 during cycle N+1.
- Snapshot outputs change only on snap.

Reset:
- All counters, snapshots, snap_valid, in_frame = 0; FSMs IDLE; frame_bad = 0.
- rst mid-frame discards the frame without counting it.

Optional Feature:
Macro XGMII_LINK_MONITOR_CAPTURE_EN.
- Defined: adds output last_word (NUM_CH*72, channel c at [c*72 +: 72] = {rxc, rxd}). It latches every word that is not full idle ({8'hFF, 64'h0707070707070707}) and holds during idle. Reset value 0; not affected by clr or snap.
- Undefined: port and its registers are absent.

Test Plan:
- Reset release with link_status=1 on ch0, idle words -> after snap: link_up_cnt[0]=1, all frame/err counters 0, snap_valid high exactly one cycle.
- ch1: SOF lane 0, 3 data words, EOF lane 2; repeat 5x -> good_frm_cnt[1]=5, bad_frm_cnt[1]=0, in_frame[1] returns 0 one cycle after each EOF word.
- ch0: SOF, data word with 0xFE control byte in lane 3, EOF -> bad_frm=1, err_cnt=1, good_frm=0. Then SOF, SOF, EOF -> bad_frm=2, good_frm=1.
- Single word {EOF lane 1, SOF lane 4} mid-frame, then EOF -> good_frm +2. Drop link_status mid-frame -> bad_frm +1, in_frame=0.
- CNT_W=8: 300 error words -> err_cnt=255 (saturated). clr and snap in the same cycle -> snapshot shows 255, live value 0; next snap shows 0.
- With XGMII_LINK_MONITOR_CAPTURE_EN: data word 0x1122334455667788/rxc 0x00 then idles -> last_word = 72'h00_1122334455667788 held; after rst -> 0.
